spi_reg_ctrl: RTL and testbench

Register-access sequencer that sits directly upstream of the SPI master driver (`spi_drv`). It accepts single read/write requests from a host over a valid/ready interface and builds a fixed-format SPI frame. It runs the `start_cmd`/`spi_drv_rdy` handshake with the driver, extracts read data from `rx_miso` and returns one response per request. A watchdog converts a hung driver handshake into an error response.

---
 rtl/spi_reg_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: single-outstanding register access sequencer in front of spi_drv.
// Host side  : req_valid/req_ready/req_wr/req_addr/req_wdata in,
//              rsp_valid/rsp_ready/rsp_rdata/rsp_err out.
// Driver side: start_cmd, n_clks, tx_data out; spi_drv_rdy, rx_miso in.
// clk / sreset: single clock, synchronous active-high reset.
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SPI_MAXLEN = 32,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          sreset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wr,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic                          start_cmd,
  input  logic                          spi_drv_rdy,
  output logic [$clog2(SPI_MAXLEN):0]   n_clks,
  output logic [SPI_MAXLEN-1:0]         tx_data,
  input  logic [SPI_MAXLEN-1:0]         rx_miso
);

  localparam int unsigned FRAME  = 1 + ADDR_W + DATA_W;
  localparam int unsigned NCLK_W = $clog2(SPI_MAXLEN) + 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SPI_MAXLEN-1:0] tx_data_q, tx_data_d;
  logic                  start_cmd_q, start_cmd_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  rd_q, rd_d;
  logic [SPI_MAXLEN-1:0] frame;
  logic                  wd_expired;
  logic                  unused_rx;

  // Only the low DATA_W bits of the received word carry register data.
  assign unused_rx = ^rx_miso[SPI_MAXLEN-1:DATA_W];

  assign n_clks     = NCLK_W'(FRAME);
  assign wd_expired = (wd_q == WD_W'(TIMEOUT));
  // Reset is folded in so the host never sees ready on the reset cycle.
  assign req_ready  = (state_q == IDLE) && spi_drv_rdy && !sreset;

  assign tx_data   = tx_data_q;
  assign start_cmd = start_cmd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Frame: read flag in the top frame bit, address below it, data in the LSBs.
  always_comb begin
    frame                    = '0;
    frame[FRAME-1]           = ~req_wr;
    frame[FRAME-2 -: ADDR_W] = req_addr;
    if (req_wr) begin
      frame[DATA_W-1:0] = req_wdata;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      start_cmd_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wd_q        <= '0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      start_cmd_q <= start_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wd_q        <= wd_d;
      rd_q        <= rd_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    start_cmd_d = start_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wd_d        = wd_q;
    rd_d        = rd_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          tx_data_d   = frame;
          rd_d        = ~req_wr;
          start_cmd_d = 1'b1;
          wd_d        = '0;
          state_d     = START;
        end
      end
      START: begin
        // Driver dropping ready is the acknowledge of start_cmd.
        if (!spi_drv_rdy) begin
          start_cmd_d = 1'b0;
          wd_d        = '0;
          state_d     = BUSY;
        end else if (wd_expired) begin
          start_cmd_d = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      BUSY: begin
        if (spi_drv_rdy) begin
          rsp_rdata_d = rd_q ? rx_miso[DATA_W-1:0] : '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wd_expired) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl with a behavioural spi_drv model.
module tb_spi_reg_ctrl;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SPI_MAXLEN = 32;
  localparam int unsigned TIMEOUT    = 20;
  localparam int          DRV_LAT    = 4;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        sreset;
  logic        req_valid, req_ready, req_wr;
  logic [6:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        start_cmd;
  logic        spi_drv_rdy;
  logic [5:0]  n_clks;
  logic [31:0] tx_data;
  logic [31:0] rx_miso;

  int errors = 0;
  int checks = 0;

  rsp_t        rsp_q[$];
  logic [31:0] tx_q[$];

  bit          drv_off, drv_stuck, drv_busy, stuck_mode;
  int          drv_cnt;
  logic [7:0]  slave_data;
  int          start_pulses = 0;
  int          start_run = 0;
  logic        prev_rdy = 1'b0;
  logic [31:0] held_tx = '0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SPI_MAXLEN(SPI_MAXLEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .sreset(sreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .start_cmd(start_cmd), .spi_drv_rdy(spi_drv_rdy), .n_clks(n_clks),
    .tx_data(tx_data), .rx_miso(rx_miso)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Driver model: accepts start_cmd while ready, busy for DRV_LAT+1 cycles, then returns slave_data.
  always @(posedge clk) begin
    if (sreset || drv_off) begin
      spi_drv_rdy <= 1'b0;
      drv_busy    <= 1'b0;
      drv_cnt     <= 0;
    end else if (drv_stuck) begin
      spi_drv_rdy <= 1'b1;
    end else if (!drv_busy) begin
      spi_drv_rdy <= 1'b1;
      if (start_cmd && spi_drv_rdy) begin
        drv_busy    <= 1'b1;
        spi_drv_rdy <= 1'b0;
        drv_cnt     <= DRV_LAT;
      end
    end else if (drv_cnt == 0) begin
      drv_busy    <= 1'b0;
      spi_drv_rdy <= 1'b1;
      rx_miso     <= {24'h0, slave_data};
    end else begin
      drv_cnt <= drv_cnt - 1;
    end
  end

  // Monitor: frame check on start_cmd rise, handshake check on fall, response scoreboard.
  always begin
    @(negedge clk);
    #1;
    if (sreset) begin
      start_run = 0;
    end else begin
      if (start_cmd) begin
        if (start_run == 0) begin
          start_pulses++;
          chk("start_rise_drv_rdy", 32'(spi_drv_rdy), 32'd1);
          if (tx_q.size() == 0) fail("start_unexpected");
          else begin
            held_tx = tx_q.pop_front();
            chk("tx_data", tx_data, held_tx);
          end
        end else begin
          chk("tx_data_hold", tx_data, held_tx);
        end
        start_run++;
      end else if (start_run > 0) begin
        if (stuck_mode) begin
          checks++;
          if (start_run < int'(TIMEOUT) || start_run > int'(TIMEOUT) + 1) begin
            errors++;
            $display("FAIL timeout_start_len: start_cmd high %0d cycles, expected %0d..%0d",
                     start_run, TIMEOUT, TIMEOUT + 1);
          end
          chk("timeout_rsp_valid_with_fall", 32'(rsp_valid), 32'd1);
        end else begin
          chk("start_fall_after_rdy_low", 32'(prev_rdy), 32'd0);
        end
        start_run = 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail("rsp_unexpected");
        else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
    prev_rdy = spi_drv_rdy;
  end

  task automatic send(input bit wr, input logic [6:0] a, input logic [7:0] d,
                      input logic [31:0] exp_tx, input bit push, input rsp_t exp, input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    tx_q.push_back(exp_tx);
    if (push) rsp_q.push_back(exp);
    for (int n = 0; n < 200 && !ok; n++) begin
      #1;
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!hold) req_valid = 1'b0;
    if (!ok) fail("accept_timeout");
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && rsp_q.size() > 0; n++) @(negedge clk);
    if (rsp_q.size() > 0) fail("response_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit bad;
    int p0;
    logic [7:0] r0;
    sreset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; drv_off = 1'b1; drv_stuck = 1'b0; stuck_mode = 1'b0;
    slave_data = 8'hFF; rx_miso = '0;

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_start_cmd", 32'(start_cmd), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("n_clks", 32'(n_clks), 32'd16);

    // Startup with driver not ready for 10 cycles
    @(negedge clk);
    sreset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (req_ready) bad = 1'b1;
    end
    chk("req_ready_while_drv_not_rdy", 32'(bad), 32'd0);
    @(negedge clk);
    drv_off = 1'b0;
    @(negedge clk);
    #1;
    chk("req_ready_after_drv_rdy", 32'(req_ready), 32'd1);

    // Write 0x15 <- 0xA5
    p0 = start_pulses;
    send(1'b1, 7'h15, 8'hA5, 32'h0000_15A5, 1'b1, rsp_t'{8'h00, 1'b0}, 1'b0);
    drain();
    chk("write_start_pulses", 32'(start_pulses - p0), 32'd1);

    // Read 0x2B -> 0x3C with host stalling the response
    slave_data = 8'h3C;
    rsp_ready  = 1'b0;
    send(1'b0, 7'h2B, 8'h00, 32'h0000_AB00, 1'b1, rsp_t'{8'h3C, 1'b0}, 1'b0);
    bad = 1'b1;
    for (int n = 0; n < 100 && bad; n++) begin
      #1;
      if (rsp_valid) bad = 1'b0;
      else @(negedge clk);
    end
    if (bad) fail("read_rsp_valid_timeout");
    r0 = rsp_rdata;
    chk("read_stall_rdata_first", 32'(r0), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("read_stall_valid", 32'(rsp_valid), 32'd1);
      chk("read_stall_rdata", 32'(rsp_rdata), 32'(r0));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    drain();

    // Back-to-back writes with req_valid held
    slave_data = 8'hFF;
    p0 = start_pulses;
    send(1'b1, 7'h01, 8'h11, 32'h0000_0111, 1'b1, rsp_t'{8'h00, 1'b0}, 1'b1);
    send(1'b1, 7'h02, 8'h22, 32'h0000_0222, 1'b1, rsp_t'{8'h00, 1'b0}, 1'b1);
    send(1'b1, 7'h03, 8'h33, 32'h0000_0333, 1'b1, rsp_t'{8'h00, 1'b0}, 1'b0);
    drain();
    chk("b2b_start_pulses", 32'(start_pulses - p0), 32'd3);
    chk("b2b_tx_queue_empty", 32'(tx_q.size()), 32'd0);

    // Stuck driver: START watchdog
    slave_data = 8'h77;
    @(negedge clk);
    drv_stuck  = 1'b1;
    stuck_mode = 1'b1;
    send(1'b0, 7'h10, 8'h00, 32'h0000_9000, 1'b1, rsp_t'{8'h00, 1'b1}, 1'b0);
    drain();
    stuck_mode = 1'b0;
    drv_stuck  = 1'b0;
    send(1'b0, 7'h10, 8'h00, 32'h0000_9000, 1'b1, rsp_t'{8'h77, 1'b0}, 1'b0);
    drain();

    // Reset while BUSY: no response, then a fresh read
    slave_data = 8'h99;
    send(1'b0, 7'h05, 8'h00, 32'h0000_8500, 1'b0, rsp_t'{8'h00, 1'b0}, 1'b0);
    bad = 1'b1;
    for (int n = 0; n < 50 && bad; n++) begin
      #1;
      if (!start_cmd && !spi_drv_rdy) bad = 1'b0;
      else @(negedge clk);
    end
    if (bad) fail("reach_busy_timeout");
    @(negedge clk);
    sreset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_start_cmd", 32'(start_cmd), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("midrst_tx_data", tx_data, 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    sreset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) bad = 1'b1;
    end
    chk("midrst_no_response", 32'(bad), 32'd0);
    slave_data = 8'h5A;
    send(1'b0, 7'h05, 8'h00, 32'h0000_8500, 1'b1, rsp_t'{8'h5A, 1'b0}, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    fail("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
